// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs decoded WISC-S25 instruction fields into 16-bit
// machine words, buffers them in a small FIFO and drains them sequentially to
// the instruction-memory write port until HLT has been written.
// Optional feature macro: ENC_RANGE_CHECK_EN (immediate range checking with
// enc_err / err_count). Without it, immediates are truncated and always pushed.
module instr_stream_encoder #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [3:0]               in_rd,
  input  logic [3:0]               in_rs,
  input  logic [3:0]               in_rt,
  input  logic [15:0]              in_imm,
  input  logic [2:0]               in_cc,
  output logic                     mem_wr_en,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              instr_count,
  output logic                     enc_err,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [LVL_W-1:0]   level_d;
  logic [15:0]        addr_q;
  logic [15:0]        count_q;
  logic [15:0]        fifo_mem [DEPTH];

  logic [15:0]        enc_word;
  logic               range_ok;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == '0);

  // Pure field packing plus the legal immediate range for each format.
  always_comb begin
    enc_word = 16'hF000;
    range_ok = 1'b1;
    case (in_opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        enc_word = {in_opcode, in_rd, in_rs, in_rt};
      end
      4'h4, 4'h5, 4'h6: begin
        enc_word = {in_opcode, in_rd, in_rs, in_imm[3:0]};
        range_ok = (in_imm[15:4] == 12'h000);
      end
      4'h8, 4'h9: begin
        // Signed 4-bit offset: everything above bit 3 must replicate the sign.
        enc_word = {in_opcode, in_rd, in_rs, in_imm[3:0]};
        range_ok = (in_imm[15:3] == {13{in_imm[3]}});
      end
      4'hA, 4'hB: begin
        enc_word = {in_opcode, in_rd, in_imm[7:0]};
        range_ok = (in_imm[15:8] == 8'h00);
      end
      4'hC: begin
        // Signed 9-bit branch offset.
        enc_word = {in_opcode, in_cc, in_imm[8:0]};
        range_ok = (in_imm[15:8] == {8{in_imm[8]}});
      end
      4'hD: begin
        enc_word = {in_opcode, in_cc, 1'b0, in_rs, 4'h0};
      end
      4'hE: begin
        enc_word = {in_opcode, in_rd, 8'h00};
      end
      default: begin
        enc_word = 16'hF000;
      end
    endcase
  end

  assign in_ready  = (state_q == S_LOAD) && !full;
  assign accept    = in_valid && in_ready;
  assign mem_wr_en = !empty && (state_q != S_DONE);
  assign pop       = mem_wr_en && mem_ready;
  assign mem_wdata = mem_wr_en ? fifo_mem[rd_ptr_q] : 16'h0000;
  assign mem_addr  = addr_q;

`ifdef ENC_RANGE_CHECK_EN
  logic       err_q;
  logic [7:0] err_cnt_q;
  logic       reject;

  assign push   = accept && range_ok;
  assign reject = accept && !range_ok;

  // Sticky error flag and saturating count of rejected tuples.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else if (reject) begin
      err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign enc_err   = err_q;
  assign err_count = err_cnt_q;
`else
  logic unused_range_ok;

  assign push            = accept;
  assign unused_range_ok = range_ok;
  assign enc_err         = 1'b0;
  assign err_count       = 8'h00;
`endif

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Sequencer: load tuples until HLT, drain the FIFO, then park in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept && (in_opcode == 4'hF)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && (level_q == LVL_W'(1))) begin
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_DONE;
        end
      endcase
    end
  end

  // Word storage; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= enc_word;
    end
  end

  // FIFO pointers, occupancy, write address and written-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= BASE_ADDR;
      count_q  <= 16'h0000;
    end else begin
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        // Wraps from FFFE to 0000 naturally.
        addr_q   <= addr_q + 16'd2;
        count_q  <= count_q + 16'd1;
      end
    end
  end

  assign instr_count = count_q;
  assign fifo_level  = level_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_DONE) && (!empty || (state_q == S_DRAIN));

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Encodes a stream of decoded WISC-S25 instruction fields into 16-bit machine words and writes them sequentially into instruction memory. It is the inverse of the testbench disassembly path: a sequencer or bench drives opcode, register and immediate fields, and this block packs, range-checks and buffers them. It then drains the words to the instruction-memory write port until HLT is written. It sits between the stimulus generator and the instruction memory in the Phase-2 test harness.

## Interface
Parameters:
- DEPTH, 8, encoded-word FIFO depth (power of two, ≥2)
- BASE_ADDR, 16'h0000, byte address of first written word (even)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  field tuple valid
- in_ready  out  1  block can accept tuple
- in_opcode  in  4  opcode
- in_rd  in  4  destination register; data register for LW/SW
- in_rs  in  4  source register 1 / base / BR target register
- in_rt  in  4  source register 2
- in_imm  in  16  immediate, two's complement
- in_cc  in  3  branch condition code
- mem_wr_en  out  1  write request
- mem_addr  out  16  byte address
- mem_wdata  out  16  encoded word
- mem_ready  in  1  memory accepts write this cycle
- busy  out  1  state != DONE and (FIFO non-empty or state == DRAIN)
- done  out  1  HLT written, sticky
- instr_count  out  16  words written to memory
- enc_err  out  1  sticky: a tuple failed range check
- err_count  out  8  rejected tuples, saturating at 255
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Encoding, bits [15:12] = opcode:
  - 0,1,2,3,7: {op, rd, rs, rt}
  - 4,5,6: {op, rd, rs, imm[3:0]}; range 0..15
  - 8,9: {op, rd, rs, imm[3:0]}; range -8..7
  - A,B: {op, rd, imm[7:0]}; range 0..255
  - C: {op, cc, imm[8:0]}; range -256..255
  - D: {op, cc, 1'b0, rs, 4'h0}
  - E: {op, rd, 8'h00}
  - F: 16'hF000
- Handshake accept: in_valid & in_ready at a rising edge.
- A tuple that fails its range check is consumed but not pushed. It sets enc_err and increments err_count.
- FSM states: LOAD → DRAIN → DONE.
  - LOAD: in_ready = !full.
  - Accepting opcode F pushes F000 and moves to DRAIN.
  - DRAIN: in_ready = 0. Move to DONE on the edge that completes the last FIFO write with the FIFO otherwise empty.
  - DONE: in_ready = 0, mem_wr_en = 0, done = 1. Leave DONE only on rst.
- Memory side: mem_wr_en = FIFO non-empty and state != DONE. mem_wdata is the FIFO head; mem_addr is the address counter.
  - A write completes when mem_wr_en & mem_ready. The FIFO pops, the address advances by 2 and instr_count increments.
  - mem_wdata and mem_addr are held stable while mem_ready is low.
- Address wrap: after a write at 16'hFFFE the address becomes 16'h0000. There is no error and no stall.
- Full boundary: in_ready is low whenever level == DEPTH, even if a pop completes in the same cycle. There is no bypass.
- Empty boundary: a push and a pop in the same cycle are legal; the level is unchanged.

## Timing
- Reset values (at the edge with rst high): in_ready=1, mem_wr_en=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, instr_count=0, enc_err=0, err_count=0, fifo_level=0. The FSM is in LOAD.
- Reset mid-operation flushes the FIFO and drops any pending write. mem_wr_en is 0 from the reset edge.
- Latency: a tuple accepted at edge N appears on mem_wr_en/mem_wdata from cycle N+1 when the FIFO was empty.
- Throughput: one tuple per cycle in, one write per cycle out while mem_ready=1.
- done rises on the edge the HLT write completes.

## Configuration
- ENC_RANGE_CHECK_EN
  - Defined: range checks as above; enc_err and err_count are live.
  - Undefined: no checks. Immediates are truncated to the field width and always pushed; enc_err and err_count are tied 0.

## Test plan
- Stream ADD(rd3,rs1,rt2), LW(rd4,rs2,imm -1), LLB(rd5,0xAB), HLT with mem_ready=1, BASE_ADDR=0 -> writes 0x0312@0000, 0x842F@0002, 0xA5AB@0004, 0xF000@0006. Then done=1, instr_count=4, in_ready=0.
- B(cc=010, imm -2), BR(cc=111, rs6), PCS(rd7) -> 0xC5FE, 0xDE60, 0xE700.
- SLL imm=16 with the macro defined -> no write, enc_err=1, err_count=1; the next valid tuple is written at an unchanged address.
- Hold mem_ready=0 and push DEPTH tuples -> fifo_level=DEPTH and in_ready=0 while mem_addr/mem_wdata stay stable. Release -> DEPTH writes on consecutive cycles.
- BASE_ADDR=16'hFFFC, three tuples -> addresses FFFC, FFFE, 0000.
- Assert rst during DRAIN with 3 queued words -> mem_wr_en=0 and fifo_level=0 from the reset edge; done stays 0 and in_ready=1.
